// File: rtl/bist_ctrl_pkg.sv
// Shared types and constants for the BIST sequencer: FSM states, pattern ordering, watchdog width.
package bist_ctrl_pkg;

  localparam int unsigned WDOG_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_NEXT,
    S_FINISH
  } bist_state_e;

  // Pattern index ordering as decoded by the BIST engine's bist_pattern_sel.
  typedef enum logic [1:0] {
    PAT_MARCH_C,
    PAT_CHECKERBOARD,
    PAT_SOLID,
    PAT_ADDR_DEC
  } bist_pattern_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bist_ctrl_pick.sv
// Find-first-set: lowest set mask bit strictly above base, or the lowest set bit overall when from_zero.
module bist_ctrl_pick
  import bist_ctrl_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = idx_width(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] base,
  input  logic          from_zero,
  output logic [PW-1:0] idx,
  output logic          valid
);

  // Scan downward so the lowest qualifying bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (mask[i] && (from_zero || (i > int'(base)))) begin
        idx   = PW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bist_ctrl.sv
// BIST run sequencer with SRAM port arbitration between BIST engine and user traffic.
// Optional watchdog per pattern enabled by defining BIST_CTRL_TIMEOUT_EN.
module bist_ctrl
  import bist_ctrl_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH   = 6,
  parameter  int unsigned DATA_WIDTH   = 8,
  parameter  int unsigned MASK_WIDTH   = 2,
  parameter  int unsigned NUM_PATTERNS = 4,
  parameter  int unsigned RST_CYCLES   = 16,
  localparam int unsigned PW           = idx_width(NUM_PATTERNS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_PATTERNS-1:0] pattern_mask,
  output logic                    busy,
  output logic                    done,
  output logic                    fail,
  output logic [NUM_PATTERNS-1:0] fail_vec,
  output logic [PW-1:0]           cur_pattern,
`ifdef BIST_CTRL_TIMEOUT_EN
  output logic                    timeout,
`endif
  output logic                    bist_rst,
  output logic                    bist_en,
  output logic [PW-1:0]           bist_pattern_sel,
  input  logic                    bist_done,
  input  logic                    bist_fail,
  input  logic                    bist_we,
  input  logic [ADDR_WIDTH-1:0]   bist_addr,
  input  logic [DATA_WIDTH-1:0]   bist_din,
  input  logic [MASK_WIDTH-1:0]   bist_wmask,
  input  logic                    user_valid,
  output logic                    user_ready,
  input  logic                    user_we,
  input  logic [ADDR_WIDTH-1:0]   user_addr,
  input  logic [DATA_WIDTH-1:0]   user_din,
  input  logic [MASK_WIDTH-1:0]   user_wmask,
  output logic                    sram_en,
  output logic                    sram_we,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_din,
  output logic [MASK_WIDTH-1:0]   sram_wmask
);

  localparam int unsigned RST_W = idx_width(RST_CYCLES);
`ifdef BIST_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = (RST_W > WDOG_W) ? RST_W : WDOG_W;
`else
  localparam int unsigned CNT_W = RST_W;
`endif

  bist_state_e             state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [NUM_PATTERNS-1:0] mask_q, mask_nx;
  logic [NUM_PATTERNS-1:0] fail_vec_nx;
  logic [PW-1:0]           cur_nx;
  logic                    done_nx, fail_nx;
  logic                    busy_nx;
  logic [PW-1:0]           pick_idx;
  logic                    pick_valid;
`ifdef BIST_CTRL_TIMEOUT_EN
  logic                    timeout_nx;
`endif

  // In IDLE search the incoming mask from bit 0; afterwards search the captured mask above cur_pattern.
  bist_ctrl_pick #(
    .N (NUM_PATTERNS)
  ) u_pick (
    .mask      ((state == S_IDLE) ? pattern_mask : mask_q),
    .base      (cur_pattern),
    .from_zero (state == S_IDLE),
    .idx       (pick_idx),
    .valid     (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    mask_nx     = mask_q;
    cur_nx      = cur_pattern;
    done_nx     = done;
    fail_nx     = fail;
    fail_vec_nx = fail_vec;
`ifdef BIST_CTRL_TIMEOUT_EN
    timeout_nx  = timeout;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          done_nx     = 1'b0;
          fail_nx     = 1'b0;
          fail_vec_nx = '0;
`ifdef BIST_CTRL_TIMEOUT_EN
          timeout_nx  = 1'b0;
`endif
          cnt_nx      = '0;
          mask_nx     = pattern_mask;
          if (pick_valid) begin
            state_nx = S_ARM;
            cur_nx   = pick_idx;
          end else begin
            state_nx = S_FINISH;
          end
        end
      end
      S_ARM: begin
        if (cnt == CNT_W'(RST_CYCLES - 1)) begin
          state_nx = S_RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        // A fail outranks a simultaneous done.
        if (bist_fail) begin
          fail_vec_nx[cur_pattern] = 1'b1;
          state_nx                 = S_NEXT;
        end else if (bist_done) begin
          state_nx = S_NEXT;
        end
`ifdef BIST_CTRL_TIMEOUT_EN
        else if (cnt == CNT_W'((2 ** WDOG_W) - 2)) begin
          fail_vec_nx[cur_pattern] = 1'b1;
          timeout_nx               = 1'b1;
          state_nx                 = S_NEXT;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
`endif
      end
      S_NEXT: begin
        cnt_nx = '0;
        if (pick_valid) begin
          state_nx = S_ARM;
          cur_nx   = pick_idx;
        end else begin
          state_nx = S_FINISH;
        end
      end
      S_FINISH: begin
        done_nx  = 1'b1;
        fail_nx  = |fail_vec;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy_nx = (state_nx == S_ARM) || (state_nx == S_RUN) || (state_nx == S_NEXT);

  // Datapath and decoded control outputs, registered off the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      mask_q      <= '0;
      cur_pattern <= '0;
      done        <= 1'b0;
      fail        <= 1'b0;
      fail_vec    <= '0;
      busy        <= 1'b0;
      bist_en     <= 1'b0;
      bist_rst    <= 1'b1;
      user_ready  <= 1'b1;
`ifdef BIST_CTRL_TIMEOUT_EN
      timeout     <= 1'b0;
`endif
    end else begin
      cnt         <= cnt_nx;
      mask_q      <= mask_nx;
      cur_pattern <= cur_nx;
      done        <= done_nx;
      fail        <= fail_nx;
      fail_vec    <= fail_vec_nx;
      busy        <= busy_nx;
      bist_en     <= (state_nx == S_RUN);
      bist_rst    <= (state_nx == S_ARM);
      user_ready  <= !busy_nx;
`ifdef BIST_CTRL_TIMEOUT_EN
      timeout     <= timeout_nx;
`endif
    end
  end

  assign bist_pattern_sel = cur_pattern;

  // Zero-latency SRAM mux; a user request is only issued when it is also accepted.
  always_comb begin
    if (bist_en) begin
      sram_en    = 1'b1;
      sram_we    = bist_we;
      sram_addr  = bist_addr;
      sram_din   = bist_din;
      sram_wmask = bist_wmask;
    end else begin
      sram_en    = user_valid & user_ready;
      sram_we    = user_we;
      sram_addr  = user_addr;
      sram_din   = user_din;
      sram_wmask = user_wmask;
    end
  end

endmodule

// File: tb/tb_bist_ctrl.sv
// Self-checking bench for bist_ctrl: directed scenarios plus randomized mask/fail plans
// checked against a per-run pattern-order and fail-vector model.
module tb_bist_ctrl;

  localparam int unsigned AW   = 6;
  localparam int unsigned DW   = 8;
  localparam int unsigned MW   = 2;
  localparam int unsigned NP   = 4;
  localparam int unsigned PW   = 2;
  localparam int unsigned RSTC = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NP-1:0] pattern_mask;
  logic          busy, done, fail;
  logic [NP-1:0] fail_vec;
  logic [PW-1:0] cur_pattern;
`ifdef BIST_CTRL_TIMEOUT_EN
  logic          timeout;
`endif
  logic          bist_rst, bist_en;
  logic [PW-1:0] bist_pattern_sel;
  logic          bist_done, bist_fail, bist_we;
  logic [AW-1:0] bist_addr;
  logic [DW-1:0] bist_din;
  logic [MW-1:0] bist_wmask;
  logic          user_valid, user_ready, user_we;
  logic [AW-1:0] user_addr;
  logic [DW-1:0] user_din;
  logic [MW-1:0] user_wmask;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [MW-1:0] sram_wmask;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bist_ctrl #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .MASK_WIDTH   (MW),
    .NUM_PATTERNS (NP),
    .RST_CYCLES   (RSTC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .pattern_mask     (pattern_mask),
    .busy             (busy),
    .done             (done),
    .fail             (fail),
    .fail_vec         (fail_vec),
    .cur_pattern      (cur_pattern),
`ifdef BIST_CTRL_TIMEOUT_EN
    .timeout          (timeout),
`endif
    .bist_rst         (bist_rst),
    .bist_en          (bist_en),
    .bist_pattern_sel (bist_pattern_sel),
    .bist_done        (bist_done),
    .bist_fail        (bist_fail),
    .bist_we          (bist_we),
    .bist_addr        (bist_addr),
    .bist_din         (bist_din),
    .bist_wmask       (bist_wmask),
    .user_valid       (user_valid),
    .user_ready       (user_ready),
    .user_we          (user_we),
    .user_addr        (user_addr),
    .user_din         (user_din),
    .user_wmask       (user_wmask),
    .sram_en          (sram_en),
    .sram_we          (sram_we),
    .sram_addr        (sram_addr),
    .sram_din         (sram_din),
    .sram_wmask       (sram_wmask)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_en(input string tag);
    int g = 0;
    while (bist_en !== 1'b1 && g < 200) begin
      g++;
      @(negedge clk);
    end
    check(tag, 64'(g < 200), 64'd1);
  endtask

  // One complete run: expected order is the set bits of mask ascending, each preceded by
  // RSTC reset cycles; expected fail_vec is mask & plan (done+fail together counts as fail).
  task automatic run_bist(input logic [NP-1:0] mask, input logic [NP-1:0] plan, input bit both);
    int            order[$];
    logic [NP-1:0] exp_vec;
    for (int i = 0; i < int'(NP); i++) if (mask[i]) order.push_back(i);
    exp_vec = mask & plan;

    pattern_mask = mask;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    pattern_mask = NP'($urandom);

    if (order.size() == 0) begin
      check("zero_busy", 64'(busy), 64'd0);
      check("zero_done_early", 64'(done), 64'd0);
      check("zero_en_a", 64'(bist_en), 64'd0);
      @(negedge clk);
      check("zero_done", 64'(done), 64'd1);
      check("zero_fail", 64'(fail), 64'd0);
      check("zero_vec", 64'(fail_vec), 64'd0);
      check("zero_en_b", 64'(bist_en), 64'd0);
      return;
    end

    check("start_busy", 64'(busy), 64'd1);
    check("start_done_clr", 64'(done), 64'd0);
    user_valid = 1'b1;
    user_addr  = AW'($urandom);
    #1;
    check("arm_stall_rdy", 64'(user_ready), 64'd0);
    check("arm_stall_sen", 64'(sram_en), 64'd0);

    foreach (order[k]) begin
      int rc     = 0;
      int en_hi  = 0;
      int lat;
      while (bist_rst === 1'b1 && rc < 200) begin
        if (bist_en === 1'b1) en_hi++;
        rc++;
        @(negedge clk);
      end
      check("arm_len", 64'(rc), 64'(RSTC));
      check("arm_en", 64'(en_hi), 64'd0);
      check("run_en", 64'(bist_en), 64'd1);
      check("run_sel", 64'(bist_pattern_sel), 64'(order[k]));
      check("run_cur", 64'(cur_pattern), 64'(order[k]));

      lat = int'($urandom_range(0, 4));
      for (int c = 0; c < lat; c++) begin
        bist_we      = 1'($urandom);
        bist_addr    = AW'($urandom);
        bist_din     = DW'($urandom);
        bist_wmask   = MW'($urandom);
        user_valid   = 1'b1;
        user_addr    = AW'($urandom);
        user_din     = DW'($urandom);
        start        = (c == 0);
        pattern_mask = NP'($urandom);
        #1;
        check("run_addr", 64'(sram_addr), 64'(bist_addr));
        check("run_din", 64'(sram_din), 64'(bist_din));
        check("run_sen", 64'(sram_en), 64'd1);
        check("run_rdy", 64'(user_ready), 64'd0);
        @(negedge clk);
      end
      start     = 1'b0;
      bist_fail = plan[order[k]];
      bist_done = !plan[order[k]] || both;
      @(negedge clk);
      bist_fail = 1'b0;
      bist_done = 1'b0;
      check("next_en", 64'(bist_en), 64'd0);
      check("next_busy", 64'(busy), 64'd1);
      check("next_rdy", 64'(user_ready), 64'd0);
      @(negedge clk);
    end

    check("fin_busy", 64'(busy), 64'd0);
    check("fin_done_early", 64'(done), 64'd0);
    user_valid = 1'b1;
    user_addr  = 6'h2A;
    user_din   = DW'($urandom);
    #1;
    check("fin_addr", 64'(sram_addr), 64'h2A);
    check("fin_din", 64'(sram_din), 64'(user_din));
    check("fin_rdy", 64'(user_ready), 64'd1);
    check("fin_sen", 64'(sram_en), 64'd1);
    @(negedge clk);
    user_valid = 1'b0;
    check("done", 64'(done), 64'd1);
    check("fail", 64'(fail), 64'(|exp_vec));
    check("fail_vec", 64'(fail_vec), 64'(exp_vec));
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;  start = 1'b0;  pattern_mask = '0;
    bist_done = 1'b0;  bist_fail = 1'b0;  bist_we = 1'b0;
    bist_addr = '0;  bist_din = '0;  bist_wmask = '0;
    user_valid = 1'b0;  user_we = 1'b0;  user_addr = '0;  user_din = '0;  user_wmask = '0;

    #2;
    check("rst_bist_rst", 64'(bist_rst), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_fail", 64'(fail), 64'd0);
    check("rst_vec", 64'(fail_vec), 64'd0);
    check("rst_cur", 64'(cur_pattern), 64'd0);
    check("rst_en", 64'(bist_en), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_bist_rst", 64'(bist_rst), 64'd0);
    check("post_rst_rdy", 64'(user_ready), 64'd1);

    run_bist(4'b0101, 4'b0000, 1'b0);
    run_bist(4'b1111, 4'b0010, 1'b0);
    run_bist(4'b0000, 4'b0000, 1'b0);
    run_bist(4'b1010, 4'b1010, 1'b1);

    // Abort mid-run: fail pattern 0, reset during pattern 1.
    pattern_mask = 4'b1111;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_en("abort_wait0");
    bist_fail = 1'b1;
    @(negedge clk);
    bist_fail = 1'b0;
    check("abort_pre_vec", 64'(fail_vec), 64'b0001);
    wait_en("abort_wait1");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_bist_rst", 64'(bist_rst), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_vec", 64'(fail_vec), 64'd0);
    check("abort_en", 64'(bist_en), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_post_rdy", 64'(user_ready), 64'd1);
    check("abort_post_busy", 64'(busy), 64'd0);
    check("abort_post_done", 64'(done), 64'd0);
    check("abort_post_bist_rst", 64'(bist_rst), 64'd0);
    run_bist(4'b0001, 4'b0000, 1'b0);

    for (int r = 0; r < 8; r++)
      run_bist(NP'($urandom_range(0, 15)), NP'($urandom), 1'($urandom));

`ifdef BIST_CTRL_TIMEOUT_EN
    begin
      int n = 0;
      pattern_mask = 4'b0001;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_en("wd_wait");
      check("wd_clear", 64'(timeout), 64'd0);
      while (bist_en === 1'b1 && n < 70000) begin
        n++;
        @(negedge clk);
      end
      check("wd_cycles", 64'(n), 64'd65535);
      check("wd_timeout", 64'(timeout), 64'd1);
      check("wd_vec", 64'(fail_vec[0]), 64'd1);
      repeat (2) @(negedge clk);
      check("wd_done", 64'(done), 64'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
